// File: rtl/fc_apb_pkg.sv
// Shared types for the FC APB completer: FSM state, error causes, default ID.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fc_apb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_t;

   localparam logic [31:0] APB_ID_VALUE = 32'hFC00_A9B4;

   // Why a transfer was rejected; checked in this priority order.
   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_MISALIGNED = 2'd1,
      ERR_RANGE      = 2'd2,
      ERR_RO         = 2'd3
   } err_cause_t;

endpackage

// File: rtl/fc_apb_completer.sv
// APB4 completer with a small word-addressed register file (reg 0 = read-only ID).
// Latency: pready rises wait_cfg cycles after the first ACCESS cycle (N+2 total incl. SETUP).
// Backpressure: wait states from wait_cfg; pslverr on misaligned, out-of-range or RO access.
//
// Ports: clk/rst (async active-high); APB psel/penable/pwrite/paddr/pwdata/pstrb/pprot in,
// pready/prdata/pslverr out; wait_cfg sampled at SETUP; wr_count counts committed writes
// (saturating); proto_err is a sticky APB sequencing-violation flag.
module fc_apb_completer
   import fc_apb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 16,
   parameter logic [31:0] ID_VALUE = APB_ID_VALUE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   input  logic [2:0]          pprot,
   input  logic [3:0]          wait_cfg,
   output logic                pready,
   output logic [DATA_W-1:0]   prdata,
   output logic                pslverr,
   output logic [15:0]         wr_count,
   output logic                proto_err
);

   localparam int unsigned      IDX_W     = $clog2(NUM_REGS);
   localparam logic [ADDR_W:0]  RANGE_LIM = (ADDR_W+1)'(NUM_REGS*4);

   apb_state_t          state, state_nxt;
   logic [3:0]          cnt;
   logic [ADDR_W-1:0]   addr_q;
   logic                wr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] strb_q;
   err_cause_t          err_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [15:0]         wr_count_q;
   logic                proto_err_q;
   logic [DATA_W-1:0]   regs [NUM_REGS];

   logic [IDX_W-1:0]    setup_idx, idx_q;
   err_cause_t          setup_err;
   logic [DATA_W-1:0]   setup_rdata;
   logic                ready, setup_fire, xfer_done, abort, violation, commit;

   // Protection bits carry no meaning for this target.
   logic unused_ok;
   assign unused_ok = ^pprot;

   assign setup_idx = paddr[2 +: IDX_W];
   assign idx_q     = addr_q[2 +: IDX_W];

   always_comb begin
      setup_err = ERR_NONE;
      if (paddr[1:0] != 2'b00)
         setup_err = ERR_MISALIGNED;
      else if ({1'b0, paddr} >= RANGE_LIM)
         setup_err = ERR_RANGE;
      else if (pwrite && (setup_idx == '0))
         setup_err = ERR_RO;
   end

   // Read data is frozen at SETUP so prdata never depends on live inputs.
   always_comb begin
      setup_rdata = '0;
      if (setup_err == ERR_NONE)
         setup_rdata = (setup_idx == '0) ? DATA_W'(ID_VALUE) : regs[setup_idx];
   end

   assign ready = (state == ST_ACCESS) && (cnt == 4'd0);

   always_comb begin
      state_nxt  = state;
      setup_fire = 1'b0;
      xfer_done  = 1'b0;
      abort      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (psel && !penable) begin
               state_nxt  = ST_ACCESS;
               setup_fire = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (!psel) begin
               state_nxt = ST_IDLE;
               abort     = 1'b1;
            end else if (penable && ready) begin
               state_nxt = ST_IDLE;
               xfer_done = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign violation = ((state == ST_IDLE) && penable) || abort ||
                      ((state == ST_ACCESS) && psel &&
                       ((paddr != addr_q) || (pwrite != wr_q) || (pwdata != wdata_q)));

   assign commit = xfer_done && wr_q && (err_q == ERR_NONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= 4'd0;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         strb_q      <= '0;
         err_q       <= ERR_NONE;
         rdata_q     <= '0;
         wr_count_q  <= 16'd0;
         proto_err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (setup_fire) begin
            cnt     <= wait_cfg;
            addr_q  <= paddr;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            err_q   <= setup_err;
            rdata_q <= setup_rdata;
         end else if ((state == ST_ACCESS) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (commit && (wr_count_q != 16'hFFFF))
            wr_count_q <= wr_count_q + 16'd1;
         if (violation)
            proto_err_q <= 1'b1;
      end
   end

   // Entry 0 is never written; reads of index 0 return ID_VALUE instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++)
            regs[i] <= '0;
      end else if (commit) begin
         for (int b = 0; b < int'(DATA_W/8); b++)
            if (strb_q[b])
               regs[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
   end

   assign pready    = ready;
   assign pslverr   = ready && (err_q != ERR_NONE);
   assign prdata    = (ready && !wr_q) ? rdata_q : '0;
   assign wr_count  = wr_count_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fc_apb_completer.sv
// Directed self-checking bench for fc_apb_completer.
// Inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Every transfer bounds its wait for pready.
module tb_fc_apb_completer;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [3:0]  wait_cfg;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic [15:0] wr_count;
   logic        proto_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] last_rdata;
   logic        last_err;
   int          last_cycles;
   int          last_low;
   logic        last_zero_ok;

   fc_apb_completer dut (
      .clk       (clk),
      .rst       (rst),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .pprot     (pprot),
      .wait_cfg  (wait_cfg),
      .pready    (pready),
      .prdata    (prdata),
      .pslverr   (pslverr),
      .wr_count  (wr_count),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called 1 ns after a rising edge; returns 1 ns after the completing edge with psel still high,
   // so consecutive calls produce back-to-back transfers.
   task automatic apb_xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [3:0] wcfg);
      bit done;
      psel     = 1'b1;
      penable  = 1'b0;
      pwrite   = w;
      paddr    = a;
      pwdata   = d;
      pstrb    = s;
      wait_cfg = wcfg;
      @(posedge clk); #1;
      penable  = 1'b1;
      wait_cfg = ~wcfg;   // must not affect the transfer in flight
      done         = 1'b0;
      last_cycles  = 1;
      last_low     = 0;
      last_zero_ok = 1'b1;
      while (!done && last_cycles < 40) begin
         @(negedge clk);
         last_cycles++;
         if (pready) begin
            last_rdata = prdata;
            last_err   = pslverr;
            done       = 1'b1;
         end else begin
            last_low++;
            if (prdata != 32'h0 || pslverr != 1'b0) last_zero_ok = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("pready_seen", {31'h0, done}, 32'h1);
      penable = 1'b0;
   endtask

   task automatic go_idle();
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = '0;
      pwdata = '0; pstrb = '0; pprot = '0; wait_cfg = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pready",    {31'h0, pready},    32'h0);
      check("rst_prdata",    prdata,             32'h0);
      check("rst_pslverr",   {31'h0, pslverr},   32'h0);
      check("rst_wr_count",  {16'h0, wr_count},  32'h0);
      check("rst_proto_err", {31'h0, proto_err}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // ID read, no wait states
      apb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, 4'd0);
      check("id_rdata",  last_rdata,             32'hFC00_A9B4);
      check("id_err",    {31'h0, last_err},      32'h0);
      check("id_cycles", last_cycles,            32'd2);

      // strobed write then immediate readback
      apb_xfer(1'b1, 16'h0008, 32'h1122_3344, 4'b0101, 4'd0);
      check("wr8_err", {31'h0, last_err}, 32'h0);
      apb_xfer(1'b0, 16'h0008, 32'h0, 4'h0, 4'd0);
      check("rd8_rdata",   last_rdata,        32'h0022_0044);
      check("wr_count_1",  {16'h0, wr_count}, 32'd1);

      // wait states
      apb_xfer(1'b1, 16'h0004, 32'hDEAD_BEEF, 4'hF, 4'd1);
      check("wr4_cycles", last_cycles, 32'd3);
      apb_xfer(1'b0, 16'h0004, 32'h0, 4'h0, 4'd3);
      check("rd4_rdata",   last_rdata,              32'hDEAD_BEEF);
      check("rd4_cycles",  last_cycles,             32'd5);
      check("rd4_low",     last_low,                32'd3);
      check("rd4_zero",    {31'h0, last_zero_ok},   32'h1);
      check("wr_count_2",  {16'h0, wr_count},       32'd2);

      // error responses
      apb_xfer(1'b1, 16'h0000, 32'h1234_5678, 4'hF, 4'd0);
      check("wr0_err",      {31'h0, last_err},  32'h1);
      check("wr0_count",    {16'h0, wr_count},  32'd2);
      apb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, 4'd0);
      check("id_after_wr0", last_rdata,         32'hFC00_A9B4);
      apb_xfer(1'b0, 16'h0041, 32'h0, 4'h0, 4'd0);
      check("rd41_err",   {31'h0, last_err}, 32'h1);
      check("rd41_rdata", last_rdata,        32'h0);
      apb_xfer(1'b0, 16'h0040, 32'h0, 4'h0, 4'd2);
      check("rd40_err",   {31'h0, last_err}, 32'h1);
      check("rd40_rdata", last_rdata,        32'h0);
      apb_xfer(1'b0, 16'h003C, 32'h0, 4'h0, 4'd0);
      check("rd3c_err",   {31'h0, last_err}, 32'h0);

      // zero-strobe write: counted, data untouched
      apb_xfer(1'b1, 16'h0008, 32'hFFFF_FFFF, 4'b0000, 4'd0);
      check("nostrb_err",   {31'h0, last_err}, 32'h0);
      check("nostrb_count", {16'h0, wr_count}, 32'd3);
      apb_xfer(1'b0, 16'h0008, 32'h0, 4'h0, 4'd0);
      check("nostrb_rdata", last_rdata,        32'h0022_0044);
      check("proto_clean",  {31'h0, proto_err}, 32'h0);

      // protocol violation: penable without SETUP
      go_idle();
      penable = 1'b1;
      @(posedge clk); #1;
      penable = 1'b0;
      @(negedge clk);
      check("proto_set", {31'h0, proto_err}, 32'h1);
      @(posedge clk); #1;
      apb_xfer(1'b0, 16'h0004, 32'h0, 4'h0, 4'd0);
      check("proto_good_rdata", last_rdata,         32'hDEAD_BEEF);
      check("proto_sticky",     {31'h0, proto_err}, 32'h1);
      go_idle();

      // reset in the middle of a waited write
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000C;
      pwdata = 32'hAABB_CCDD; pstrb = 4'hF; wait_cfg = 4'd5;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      check("mid_rst_pready", {31'h0, pready}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_count", {16'h0, wr_count},  32'd0);
      check("mid_rst_proto", {31'h0, proto_err}, 32'h0);
      apb_xfer(1'b0, 16'h000C, 32'h0, 4'h0, 4'd0);
      check("mid_rst_rdc", last_rdata, 32'h0);
      apb_xfer(1'b0, 16'h0008, 32'h0, 4'h0, 4'd0);
      check("mid_rst_rd8", last_rdata, 32'h0);
      go_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fc_apb_completer.md
# fc_apb_completer

Synthesizable APB4 completer (responder) for the FC HDL testbench top: the target end of the APB link driven by the APB VIP requester when `APB_ENV_ENABLE` is set. It exposes a small word-addressed register file. It inserts a programmable number of wait states and flags bad accesses with PSLVERR. It also keeps a write counter and a sticky protocol-error flag that the TB can sample.

## Interface
- `ADDR_W`, 16, PADDR width
- `DATA_W`, 32, PWDATA/PRDATA width (fixed to 32 in this release)
- `NUM_REGS`, 16, number of 32-bit registers (power of 2, 2..256)
- `ID_VALUE`, 32'hFC00_A9B4, read-only contents of register 0
- `clk` in 1: single clock; all logic is on the rising edge
- `rst` in 1: asynchronous, active-high reset
- `psel` in 1: APB select
- `penable` in 1: APB enable (access phase)
- `pwrite` in 1: 1 means write
- `paddr` in ADDR_W: byte address
- `pwdata` in DATA_W: write data
- `pstrb` in DATA_W/8: byte strobes
- `pprot` in 3: accepted and ignored
- `wait_cfg` in 4: wait states per transfer, sampled in the SETUP cycle
- `pready` out 1: transfer complete
- `prdata` out DATA_W: read data, valid when `pready` is high and the transfer is a read
- `pslverr` out 1: error response, valid only when `pready` is high
- `wr_count` out 16: count of successful writes, saturating at 16'hFFFF
- `proto_err` out 1: sticky flag for APB sequencing violations

## Operation
- **FSM states:** IDLE and ACCESS.
- **IDLE to ACCESS:** taken at a rising edge with `psel=1` and `penable=0` (the SETUP cycle). On that edge the block latches address, write flag, write data, strobes and `wait_cfg` into the wait counter `cnt`.
- **ACCESS behaviour:**
  - `pready = (cnt==0)`.
  - Each edge with `cnt!=0` decrements `cnt`.
  - On the edge where `psel & penable & pready` is true, the transfer completes and the FSM returns to IDLE.
- **Address decode:** word index `idx = paddr[2 +: log2(NUM_REGS)]`. The transfer errors if any of these hold:
  - `paddr[1:0] != 0`
  - `paddr >= NUM_REGS*4`
  - a write to index 0
- **Reads:**
  - `prdata` is the register value captured at the SETUP edge; index 0 returns `ID_VALUE`.
  - On error, `prdata = 0`.
  - `prdata` is 0 whenever `pready` is low.
- **Writes:**
  - Commit at the completing edge, merged per byte using `pstrb`.
  - An all-zero `pstrb` is a legal no-op write and still increments `wr_count`.
  - An errored write changes no register and does not increment `wr_count`.
- **pslverr:** equals `pready & err`, where `err` is computed at SETUP.
- **proto_err** is set, and stays set until reset, on any of:
  - `penable=1` while in IDLE
  - `psel` dropping in ACCESS before completion
  - `paddr`, `pwrite` or `pwdata` changing during ACCESS
- **Abort recovery:** when `psel` drops mid-ACCESS, the FSM returns to IDLE with no commit.

## Timing
- **Reset values:**
  - `pready=0`, `prdata=0`, `pslverr=0`, `wr_count=0`, `proto_err=0`
  - FSM in IDLE
  - registers 1..NUM_REGS-1 equal 0
- **Latency:** with `wait_cfg=N`, `pready` rises N cycles after the first ACCESS cycle. Total transfer length is N+2 cycles including SETUP.
- **wait_cfg changes:** changing `wait_cfg` during ACCESS has no effect on the current transfer.
- **Back-to-back transfers:** a new SETUP may arrive on the cycle right after completion (`psel` held, `penable=0`). IDLE accepts it with no bubble.
- **Register outputs:** all outputs except `pready`, `pslverr` and `prdata` are registered. Those three are decoded from registered state only, never from inputs.
- **Reset mid-transfer:** the transfer is dropped immediately (asynchronously), with no partial write.
- **Write-then-read:** a write followed immediately by a read of the same index returns the new value.

## Structure
- Shared package `fc_apb_pkg`:
  - FSM state enum
  - `APB_ID_VALUE` default
  - error-cause enum (MISALIGNED, RANGE, RO)
- No sub-module. The register file is a local array inside `fc_apb_completer`.
- Instantiated inside `apb_svt_dut_sv_wrapper.svh` under `APB_ENV_ENABLE`.

## Test plan
1. **Reset and ID read:** reset, then read 0x0 with `wait_cfg=0` -> `pready` in the first ACCESS cycle, `prdata=32'hFC00_A9B4`, `pslverr=0`.
2. **Strobed write and readback:** write 0x8 data 32'h1122_3344 with `pstrb=4'b0101`, then read 0x8 -> `prdata=32'h0022_0044`, `wr_count=1`.
3. **Wait states:** `wait_cfg=3`, read 0x4 -> `pready` low for 3 ACCESS cycles and high in the 4th. Total transfer length is 5 cycles.
4. **Error responses:**
   - write to 0x0 -> `pslverr=1`, `wr_count` unchanged
   - read 0x41 -> `pslverr=1`, `prdata=0`
   - read 0x40 with NUM_REGS=16 -> `pslverr=1`
5. **Protocol violation:** `penable=1` with no preceding SETUP -> `proto_err=1`, and it stays set through later good transfers.
6. **Reset mid-transfer:** assert `rst` during ACCESS of a write to 0xC with `wait_cfg=5`, then release and read 0xC -> `prdata=0`, `wr_count=0`, `proto_err=0`.
